ctrl_pipe: RTL and testbench
============================

Name: ctrl_pipe

Overview:
- Receiving end of the decode-stage control bundle produced by the main/ALU decoders.
- Carries the per-instruction control word through the D→E, E→M and M→W pipeline registers, and handles stall and flush.
- Resolves the branch/jump decision in Execute (PCSrcE) from the ALU zero flag.
- Exports per-stage RegWrite/Rd/ResultSrc to the hazard unit for forwarding and load-use detection.

Parameters:
- RW, 5, destination register index width
- ALUCW, 4, ALU control width (matches ALUControlD)

Ports:
- clk  in  1  core clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all pipeline registers
- ValidD  in  1  Decode slot holds a real instruction
- RegWriteD  in  1  decode control
- ResultSrcD  in  2  decode control (00 ALU, 01 mem, 10 PC+4)
- MemWriteD  in  1  decode control
- JumpD  in  1  decode control
- JumpRegD  in  1  decode control (JALR)
- BranchD  in  1  decode control
- ALUControlD  in  ALUCW  decode control
- ALUSrcD  in  1  decode control
- InverseBrCondD  in  1  invert the zero test (bne/bge/bgeu style)
- RdD  in  RW  destination register
- StallE  in  1  hold Execute register, bubble into Memory
- FlushE  in  1  replace Execute register with bubble
- ZeroE  in  1  ALU zero/compare flag for the instruction in Execute
- ALUControlE  out  ALUCW  Execute ALU op
- ALUSrcE  out  1
- ResultSrcE0  out  1  ResultSrcE[0], load in Execute (load-use detection)
- PCSrcE  out  1  redirect PC this cycle
- JumpRegE  out  1  target from register (JALR) vs PC-relative
- RdE, RdM, RdW  out  RW  per-stage destination
- RegWriteM, RegWriteW  out  1  per-stage write enables
- MemWriteM  out  1  data-memory write strobe
- ResultSrcW  out  2  writeback mux select

Behaviour:
- Three register banks: E (full D bundle + valid), M (RegWrite, ResultSrc, MemWrite, Rd, valid), W (RegWrite, ResultSrc, Rd, valid).
- Reset (async, any time including mid-stream): every bank goes to all-zero, which is the bubble state. All outputs are 0 while reset is held and in the first cycle after release. PCSrcE = 0.
- Bubble = all control bits 0, Rd = 0, valid = 0. A bubble never writes the register file or memory.
- Capture into E:
  - RegWriteE <= RegWriteD & ValidD & (RdD != 0). x0 writes are suppressed here, so downstream forwarding never matches x0.
  - MemWriteE, JumpE, BranchE are gated by ValidD.
- Per-edge update priority for E: FlushE → bubble; else StallE → hold; else capture D.
- M bank: if StallE, M <= bubble; else M <= E (only RegWrite, ResultSrc, MemWrite, Rd, valid).
- W bank: W <= M every cycle, with no stall.
- FlushE together with StallE: flush wins, so E becomes a bubble and M also receives a bubble.
- PCSrcE is combinational: validE & (JumpE | (BranchE & (ZeroE ^ InverseBrCondE))).
  - Asserted for exactly one cycle per taken branch or jump, unless E is held by StallE, in which case it stays asserted while held.
  - The block does not self-flush; the hazard unit drives FlushE/FlushD from PCSrcE.
- JumpRegE = JumpRegE_reg & validE.
- ALUControlE, ALUSrcE and ResultSrcE0 come straight from E; all three are 0 for a bubble.
- Latency: a D bundle appears on E outputs 1 cycle after capture, on M outputs after 2, on W outputs after 3 (absent stalls/flushes).
- No combinational path from D inputs to any output.

Test Plan:
- Reset mid-stream:
  - Stimulus: fill pipe with RegWriteD=1, RdD=5, MemWriteD=1 for 3 cycles, then assert reset asynchronously between edges.
  - Response: RegWriteM/W, MemWriteM, RdE/M/W all drop to 0 immediately, with no clock edge needed.
- Straight flow:
  - Stimulus: a single add (RegWriteD=1, RdD=7, ResultSrcD=00, ALUControlD=4'b0000) followed by bubbles.
  - Response: RdE=7 at cycle+1, RegWriteM=1/RdM=7 at +2, RegWriteW=1/RdW=7/ResultSrcW=00 at +3, then all 0.
- x0 suppression:
  - Stimulus: RegWriteD=1, RdD=0.
  - Response: RegWriteM and RegWriteW stay 0 throughout.
- Branch resolution:
  - BranchD=1, InverseBrCondD=0, ZeroE=1 → PCSrcE=1.
  - Same with InverseBrCondD=1 → PCSrcE=0.
  - JumpD=1, JumpRegD=1, any ZeroE → PCSrcE=1, JumpRegE=1.
- Load-use stall:
  - Stimulus: load (ResultSrcD=01, RdD=3) in E, StallE=1 for one cycle.
  - Response: E holds (ResultSrcE0 stays 1, RdE=3); the next cycle's M shows a bubble (RegWriteM=0, MemWriteM=0); then the load proceeds to M with RdM=3.
- Flush priority:
  - Stimulus: a taken branch in E with FlushE=1 and StallE=1 asserted on the same edge.
  - Response: next cycle E is a bubble (PCSrcE=0, ALUControlE=0) and M is a bubble.

Source files
------------

// File: rtl/ctrl_pipe.sv
// Control-word pipeline for the D->E, E->M and M->W stages with stall/flush handling.
// Resolves the branch/jump redirect in Execute and exports per-stage hazard information.
module ctrl_pipe #(
  parameter int RW    = 5,
  parameter int ALUCW = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ValidD,
  input  logic             RegWriteD,
  input  logic [1:0]       ResultSrcD,
  input  logic             MemWriteD,
  input  logic             JumpD,
  input  logic             JumpRegD,
  input  logic             BranchD,
  input  logic [ALUCW-1:0] ALUControlD,
  input  logic             ALUSrcD,
  input  logic             InverseBrCondD,
  input  logic [RW-1:0]    RdD,
  input  logic             StallE,
  input  logic             FlushE,
  input  logic             ZeroE,
  output logic [ALUCW-1:0] ALUControlE,
  output logic             ALUSrcE,
  output logic             ResultSrcE0,
  output logic             PCSrcE,
  output logic             JumpRegE,
  output logic [RW-1:0]    RdE,
  output logic [RW-1:0]    RdM,
  output logic [RW-1:0]    RdW,
  output logic             RegWriteM,
  output logic             RegWriteW,
  output logic             MemWriteM,
  output logic [1:0]       ResultSrcW
);

  logic             valid_e;
  logic             reg_write_e;
  logic [1:0]       result_src_e;
  logic             mem_write_e;
  logic             jump_e;
  logic             jump_reg_e;
  logic             branch_e;
  logic [ALUCW-1:0] alu_control_e;
  logic             alu_src_e;
  logic             inv_br_e;
  logic [RW-1:0]    rd_e;

  logic             valid_m;
  logic             reg_write_m;
  logic [1:0]       result_src_m;
  logic             mem_write_m;
  logic [RW-1:0]    rd_m;

  logic             valid_w;
  logic             reg_write_w;
  logic [1:0]       result_src_w;
  logic [RW-1:0]    rd_w;

  // Execute bank: flush beats stall; x0 writes are dropped so forwarding never matches x0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_e       <= 1'b0;
      reg_write_e   <= 1'b0;
      result_src_e  <= 2'b00;
      mem_write_e   <= 1'b0;
      jump_e        <= 1'b0;
      jump_reg_e    <= 1'b0;
      branch_e      <= 1'b0;
      alu_control_e <= '0;
      alu_src_e     <= 1'b0;
      inv_br_e      <= 1'b0;
      rd_e          <= '0;
    end else if (FlushE) begin
      valid_e       <= 1'b0;
      reg_write_e   <= 1'b0;
      result_src_e  <= 2'b00;
      mem_write_e   <= 1'b0;
      jump_e        <= 1'b0;
      jump_reg_e    <= 1'b0;
      branch_e      <= 1'b0;
      alu_control_e <= '0;
      alu_src_e     <= 1'b0;
      inv_br_e      <= 1'b0;
      rd_e          <= '0;
    end else if (!StallE) begin
      valid_e       <= ValidD;
      reg_write_e   <= RegWriteD & ValidD & (RdD != '0);
      result_src_e  <= ResultSrcD;
      mem_write_e   <= MemWriteD & ValidD;
      jump_e        <= JumpD & ValidD;
      jump_reg_e    <= JumpRegD;
      branch_e      <= BranchD & ValidD;
      alu_control_e <= ALUControlD;
      alu_src_e     <= ALUSrcD;
      inv_br_e      <= InverseBrCondD;
      rd_e          <= RdD;
    end
  end

  // Memory bank: a held Execute slot leaves a bubble behind it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_m      <= 1'b0;
      reg_write_m  <= 1'b0;
      result_src_m <= 2'b00;
      mem_write_m  <= 1'b0;
      rd_m         <= '0;
    end else if (StallE) begin
      valid_m      <= 1'b0;
      reg_write_m  <= 1'b0;
      result_src_m <= 2'b00;
      mem_write_m  <= 1'b0;
      rd_m         <= '0;
    end else begin
      valid_m      <= valid_e;
      reg_write_m  <= reg_write_e;
      result_src_m <= result_src_e;
      mem_write_m  <= mem_write_e;
      rd_m         <= rd_e;
    end
  end

  // Writeback bank: follows Memory every cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_w      <= 1'b0;
      reg_write_w  <= 1'b0;
      result_src_w <= 2'b00;
      rd_w         <= '0;
    end else begin
      valid_w      <= valid_m;
      reg_write_w  <= reg_write_m;
      result_src_w <= result_src_m;
      rd_w         <= rd_m;
    end
  end

  // Redirect decision depends on the live ALU flag, so it stays combinational
  always_comb begin
    PCSrcE   = valid_e & (jump_e | (branch_e & (ZeroE ^ inv_br_e)));
    JumpRegE = jump_reg_e & valid_e;
  end

  assign ALUControlE = alu_control_e;
  assign ALUSrcE     = alu_src_e;
  assign ResultSrcE0 = result_src_e[0];
  assign RdE         = rd_e;
  assign RdM         = rd_m;
  assign RdW         = rd_w;
  assign RegWriteM   = reg_write_m;
  assign RegWriteW   = reg_write_w;
  assign MemWriteM   = mem_write_m;
  assign ResultSrcW  = result_src_w;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: expected per-cycle outputs are queued at issue time
// and compared one time unit after each rising edge.
module tb_ctrl_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic       ValidD, RegWriteD, MemWriteD, JumpD, JumpRegD, BranchD, ALUSrcD, InverseBrCondD;
  logic [1:0] ResultSrcD;
  logic [3:0] ALUControlD;
  logic [4:0] RdD;
  logic       StallE, FlushE, ZeroE;
  logic [3:0] ALUControlE;
  logic       ALUSrcE, ResultSrcE0, PCSrcE, JumpRegE;
  logic [4:0] RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, MemWriteM;
  logic [1:0] ResultSrcW;

  ctrl_pipe #(.RW(5), .ALUCW(4)) dut (
    .clk(clk), .reset(reset), .ValidD(ValidD), .RegWriteD(RegWriteD),
    .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD), .JumpD(JumpD), .JumpRegD(JumpRegD),
    .BranchD(BranchD), .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD),
    .InverseBrCondD(InverseBrCondD), .RdD(RdD), .StallE(StallE), .FlushE(FlushE),
    .ZeroE(ZeroE), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .ResultSrcE0(ResultSrcE0),
    .PCSrcE(PCSrcE), .JumpRegE(JumpRegE), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemWriteM(MemWriteM),
    .ResultSrcW(ResultSrcW)
  );

  always #5 clk = ~clk;

  localparam int RDE = 0, RDM = 1, RDW = 2, RWM = 3, RWW = 4, MWM = 5;
  localparam int RSW = 6, PCS = 7, JRE = 8, ACE = 9, ASE = 10, RS0 = 11, NSIG = 12;

  typedef struct {
    int          due;
    int          id;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   c;

  function automatic logic [31:0] sig(input int id);
    case (id)
      RDE:     return {27'd0, RdE};
      RDM:     return {27'd0, RdM};
      RDW:     return {27'd0, RdW};
      RWM:     return {31'd0, RegWriteM};
      RWW:     return {31'd0, RegWriteW};
      MWM:     return {31'd0, MemWriteM};
      RSW:     return {30'd0, ResultSrcW};
      PCS:     return {31'd0, PCSrcE};
      JRE:     return {31'd0, JumpRegE};
      ACE:     return {28'd0, ALUControlE};
      ASE:     return {31'd0, ALUSrcE};
      RS0:     return {31'd0, ResultSrcE0};
      default: return 32'd0;
    endcase
  endfunction

  function automatic string nm(input int id);
    case (id)
      RDE:     return "RdE";
      RDM:     return "RdM";
      RDW:     return "RdW";
      RWM:     return "RegWriteM";
      RWW:     return "RegWriteW";
      MWM:     return "MemWriteM";
      RSW:     return "ResultSrcW";
      PCS:     return "PCSrcE";
      JRE:     return "JumpRegE";
      ACE:     return "ALUControlE";
      ASE:     return "ALUSrcE";
      RS0:     return "ResultSrcE0";
      default: return "unknown";
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, act, exp);
    end
  endtask

  task automatic push(input int due, input int id, input logic [31:0] val);
    exp_t e;
    int   pos;
    e.due = due; e.id = id; e.val = val;
    pos = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].due > due) begin
        pos = i;
        break;
      end
    end
    sb.insert(pos, e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      check_val(nm(e.id), sig(e.id), e.val);
    end
  endtask

  task automatic drv(input logic v, rw, input logic [1:0] rs, input logic mw, j, jr, br,
                     input logic [3:0] ac, input logic as, inv, input logic [4:0] rd);
    ValidD = v; RegWriteD = rw; ResultSrcD = rs; MemWriteD = mw; JumpD = j;
    JumpRegD = jr; BranchD = br; ALUControlD = ac; ALUSrcD = as;
    InverseBrCondD = inv; RdD = rd;
  endtask

  task automatic bubble();
    drv(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < NSIG; i++) check_val({tag, "_", nm(i)}, sig(i), 32'd0);
  endtask

  initial begin
    reset = 1'b1; StallE = 1'b0; FlushE = 1'b0; ZeroE = 1'b0;
    bubble();
    @(posedge clk);
    #1;
    check_all_zero("rst_held");
    #2 reset = 1'b0;
    #1 check_all_zero("rst_release");

    // straight flow: single add to x7
    c = cyc;
    drv(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 5'd7);
    push(c+1, RDE, 7); push(c+2, RDE, 0);
    push(c+2, RWM, 1); push(c+2, RDM, 7);
    push(c+3, RWW, 1); push(c+3, RDW, 7); push(c+3, RSW, 0); push(c+3, RWM, 0);
    push(c+4, RWW, 0); push(c+4, RDW, 0);
    tick(); bubble(); tick(); tick(); tick();

    // load then store
    c = cyc;
    drv(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 5'd12);
    push(c+1, RS0, 1); push(c+1, ASE, 1);
    push(c+3, RSW, 1); push(c+3, RDW, 12); push(c+3, RWW, 1);
    tick();
    drv(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 5'd0);
    push(c+2, RS0, 0); push(c+3, MWM, 1); push(c+3, RWM, 0); push(c+4, MWM, 0);
    tick(); bubble(); tick(); tick(); tick();

    // invalid slot with stray control bits never acts
    c = cyc;
    drv(1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 5'd0);
    ZeroE = 1'b1;
    push(c+1, PCS, 0); push(c+2, RWM, 0); push(c+2, MWM, 0);
    tick(); bubble(); ZeroE = 1'b0; tick();

    // x0 write suppression
    c = cyc;
    drv(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0);
    push(c+2, RWM, 0); push(c+3, RWW, 0);
    tick(); bubble(); tick(); tick(); tick();

    // branch resolution
    c = cyc;
    drv(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 4'h1, 1'b0, 1'b0, 5'd0); ZeroE = 1'b1;
    push(c+1, PCS, 1); push(c+1, JRE, 0);
    tick();
    drv(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 4'h1, 1'b0, 1'b1, 5'd0); ZeroE = 1'b1;
    push(c+2, PCS, 0);
    tick();
    drv(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 4'h1, 1'b0, 1'b1, 5'd0); ZeroE = 1'b0;
    push(c+3, PCS, 1);
    tick();
    drv(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 4'h1, 1'b0, 1'b0, 5'd0); ZeroE = 1'b0;
    push(c+4, PCS, 0);
    tick();
    drv(1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 5'd1); ZeroE = 1'b0;
    push(c+5, PCS, 1); push(c+5, JRE, 1);
    tick();
    bubble();
    push(c+6, PCS, 0); push(c+6, JRE, 0); push(c+7, RSW, 2); push(c+7, RDW, 1);
    tick(); tick(); tick();

    // load-use stall
    c = cyc;
    drv(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 5'd3);
    push(c+1, RS0, 1); push(c+1, RDE, 3);
    tick();
    drv(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 5'd9); StallE = 1'b1;
    push(c+2, RS0, 1); push(c+2, RDE, 3); push(c+2, RWM, 0); push(c+2, MWM, 0);
    push(c+2, RDM, 0);
    tick();
    StallE = 1'b0;
    push(c+3, RDE, 9); push(c+3, RDM, 3); push(c+3, RWM, 1); push(c+3, RWW, 0);
    tick();
    bubble();
    push(c+4, RDW, 3); push(c+4, RSW, 1); push(c+4, RWW, 1); push(c+4, RDM, 9);
    tick(); tick(); tick();

    // flush wins over stall
    c = cyc;
    drv(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 4'h6, 1'b0, 1'b0, 5'd11); ZeroE = 1'b1;
    push(c+1, PCS, 1); push(c+1, ACE, 6); push(c+1, RDE, 11);
    tick();
    drv(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 1'b0, 1'b0, 5'd4);
    FlushE = 1'b1; StallE = 1'b1;
    push(c+2, PCS, 0); push(c+2, ACE, 0); push(c+2, RDE, 0); push(c+2, RDM, 0);
    push(c+2, RWM, 0);
    tick();
    FlushE = 1'b0; StallE = 1'b0; ZeroE = 1'b0; bubble();
    push(c+3, RDM, 0); push(c+3, RDW, 0);
    tick(); tick(); tick();

    // reset mid-stream
    c = cyc;
    drv(1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 5'd5);
    push(c+3, RDE, 5); push(c+3, RDM, 5); push(c+3, RWM, 1); push(c+3, MWM, 1);
    push(c+3, RDW, 5); push(c+3, RWW, 1);
    tick(); tick(); tick();
    #2 reset = 1'b1;
    #1 check_all_zero("rst_async");
    #2 reset = 1'b0;
    #1 check_all_zero("rst_after");
    bubble();
    tick();

    check_val("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
